// File: rtl/uart_receiver_pkg.sv
// Shared definitions for the UART receive path: parity codes, FSM state
// encodings and the parity-mismatch helper.
package uart_receiver_pkg;

  // Parity mode codes, also used by the transmitter.
  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Receive FSM state encodings.
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_HIGH = 3'd5;

  // xor_all is the XOR of every data bit and the received parity bit.
  function automatic logic parity_mismatch(input int mode, input logic xor_all);
    case (mode)
      PARITY_ODD:  return ~xor_all;
      PARITY_EVEN: return xor_all;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_receiver_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input bit.
module uart_bit_sync #(
  parameter logic INIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Double-register the input; both stages reset to the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= INIT;
      r_sync <= INIT;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// UART receive core: synchronises rx, validates the start bit, samples each
// bit at mid-bit, checks parity/stop and holds one word until acknowledged.
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int PARITY_BIT = 0,
  parameter int DATA_LEN   = 8,
  parameter int STOP_BIT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                rx_data_readed,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_data_ready,
  output logic                parity_err,
  output logic                frame_err,
  output logic                overrun
);

  localparam int BIT_TICKS = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = BIT_TICKS / 2;
  localparam int CNT_W     = (BIT_TICKS > 2) ? $clog2(BIT_TICKS) : 1;

  logic                w_rx_s;
  logic                w_tick;
  logic                w_data_smp;
  logic                w_stop_ok;

  logic [2:0]          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_idx;
  logic                r_stop_idx;
  logic                r_par_err;
  logic                r_done;
  logic                r_ferr_p;

  logic [DATA_LEN-1:0] r_shift;
  logic [DATA_LEN-1:0] r_word;
  logic                r_word_perr;

  logic [DATA_LEN-1:0] r_rx_data;
  logic                r_ready;
  logic                r_perr;
  logic                r_frame_err;
  logic                r_overrun;

  uart_bit_sync #(.INIT(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  assign w_tick     = (r_cnt == '0);
  assign w_data_smp = (r_state == S_DATA) && w_tick;
  assign w_stop_ok  = (r_state == S_STOP) && w_tick && w_rx_s &&
                      (r_stop_idx == 1'(STOP_BIT - 1));

  // Frame FSM with the shared baud down-counter; a sample is taken when the
  // counter reaches zero, and the counter is reloaded for the next bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_par_err  <= 1'b0;
      r_done     <= 1'b0;
      r_ferr_p   <= 1'b0;
    end else begin
      r_done   <= 1'b0;
      r_ferr_p <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            r_state <= S_START;
            r_cnt   <= CNT_W'(HALF - 1);
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_rx_s) begin
              r_state <= S_IDLE;
            end else begin
              r_state   <= S_DATA;
              r_idx     <= '0;
              r_par_err <= 1'b0;
              r_cnt     <= CNT_W'(BIT_TICKS - 1);
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt <= CNT_W'(BIT_TICKS - 1);
            if (r_idx == 4'(DATA_LEN - 1)) begin
              r_state    <= (PARITY_BIT != PARITY_NONE) ? S_PARITY : S_STOP;
              r_stop_idx <= 1'b0;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par_err  <= parity_mismatch(PARITY_BIT, (^r_shift) ^ w_rx_s);
            r_state    <= S_STOP;
            r_stop_idx <= 1'b0;
            r_cnt      <= CNT_W'(BIT_TICKS - 1);
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (!w_rx_s) begin
              r_ferr_p <= 1'b1;
              r_state  <= S_WAIT_HIGH;
            end else if (w_stop_ok) begin
              // Return to IDLE right at the last stop sample so a start bit
              // that follows immediately is not missed.
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_stop_idx <= 1'b1;
              r_cnt      <= CNT_W'(BIT_TICKS - 1);
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must go high before a new start counts.
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shift data in LSB-first and capture the completed word at the stop sample.
  always_ff @(posedge clk) begin
    if (w_data_smp) r_shift <= {w_rx_s, r_shift[DATA_LEN-1:1]};
    if (w_stop_ok) begin
      r_word      <= r_shift;
      r_word_perr <= r_par_err;
    end
  end

  // Consumer handshake: deliver, drop on overrun, or clear on acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data   <= '0;
      r_ready     <= 1'b0;
      r_perr      <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= r_ferr_p;
      if (r_done) begin
        if (!r_ready || rx_data_readed) begin
          r_rx_data <= r_word;
          r_perr    <= r_word_perr;
          r_ready   <= 1'b1;
          // The held word was consumed this cycle, so nothing was lost.
          if (rx_data_readed) r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_ready && rx_data_readed) begin
        r_ready   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign rx_data       = r_rx_data;
  assign rx_data_ready = r_ready;
  assign parity_err    = r_perr;
  assign frame_err     = r_frame_err;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: three instances (8N1, 8E1, 8N2) driven
// with serial frames; expected words go through a scoreboard queue.
module tb_uart_receiver;
  import uart_receiver_pkg::*;

  localparam int BT = 10;

  typedef struct {
    int         k;
    logic [7:0] d;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_i  [3];
  logic       ack_i [3];
  logic [7:0] data_o[3];
  logic       rdy_o [3];
  logic       perr_o[3];
  logic       ferr_o[3];
  logic       ovr_o [3];

  int   cyc = 0;
  int   rise_cnt[3] = '{0, 0, 0};
  int   rise_cyc[3] = '{0, 0, 0};
  int   ferr_cnt[3] = '{0, 0, 0};
  int   ferr_cyc[3] = '{0, 0, 0};
  logic rdy_prev[3] = '{1'b0, 1'b0, 1'b0};

  int   checks   = 0;
  int   failures = 0;
  int   e_last   = 0;
  int   e;
  int   rc;
  int   fc;
  exp_t sb[$];

  uart_receiver #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_BIT(0),
                  .DATA_LEN(8), .STOP_BIT(1)) u_n1 (
    .clk(clk), .rst(rst), .rx(rx_i[0]), .rx_data_readed(ack_i[0]),
    .rx_data(data_o[0]), .rx_data_ready(rdy_o[0]), .parity_err(perr_o[0]),
    .frame_err(ferr_o[0]), .overrun(ovr_o[0]));

  uart_receiver #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_BIT(2),
                  .DATA_LEN(8), .STOP_BIT(1)) u_e1 (
    .clk(clk), .rst(rst), .rx(rx_i[1]), .rx_data_readed(ack_i[1]),
    .rx_data(data_o[1]), .rx_data_ready(rdy_o[1]), .parity_err(perr_o[1]),
    .frame_err(ferr_o[1]), .overrun(ovr_o[1]));

  uart_receiver #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_BIT(0),
                  .DATA_LEN(8), .STOP_BIT(2)) u_n2 (
    .clk(clk), .rst(rst), .rx(rx_i[2]), .rx_data_readed(ack_i[2]),
    .rx_data(data_o[2]), .rx_data_ready(rdy_o[2]), .parity_err(perr_o[2]),
    .frame_err(ferr_o[2]), .overrun(ovr_o[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the edge number at which ready rises and frame_err pulses.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rdy_o[k] && !rdy_prev[k]) begin
        rise_cnt[k] <= rise_cnt[k] + 1;
        rise_cyc[k] <= cyc;
      end
      rdy_prev[k] <= rdy_o[k];
      if (ferr_o[k]) begin
        ferr_cnt[k] <= ferr_cnt[k] + 1;
        ferr_cyc[k] <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one frame starting just after a rising edge; e_last gets that edge.
  task automatic send_frame(input int k, input logic [7:0] d, input int par,
                            input int nstop, input int stop_low);
    e_last = cyc;
    rx_i[k] = 1'b0;
    repeat (BT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_i[k] = d[i];
      repeat (BT) @(posedge clk);
      #1;
    end
    if (par >= 0) begin
      rx_i[k] = par[0];
      repeat (BT) @(posedge clk);
      #1;
    end
    if (stop_low > 0) begin
      rx_i[k] = 1'b0;
      repeat (stop_low) @(posedge clk);
      #1;
      rx_i[k] = 1'b1;
    end else begin
      rx_i[k] = 1'b1;
      repeat (BT * nstop) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rdy(input int k, input int budget);
    int n = 0;
    while (!rdy_o[k] && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready_within_budget", rdy_o[k], 1'b1);
  endtask

  task automatic pop_check(input int k);
    exp_t x;
    chk("sb_nonempty", sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("sb_inst", k, x.k);
      chk("sb_data", data_o[k], x.d);
      chk("sb_parity_err", perr_o[k], x.p);
    end
  endtask

  task automatic ack_pulse(input int k);
    ack_i[k] = 1'b1;
    @(posedge clk);
    #1;
    ack_i[k] = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rx_i[k]  = 1'b1;
      ack_i[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", rdy_o[k], 1'b0);
      chk("reset_data", data_o[k], 8'h00);
      chk("reset_perr", perr_o[k], 1'b0);
      chk("reset_ferr", ferr_o[k], 1'b0);
      chk("reset_ovr", ovr_o[k], 1'b0);
    end
    chk("reset_state", u_n1.r_state, S_IDLE);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 8N1 single word, then acknowledge
    rc = rise_cnt[0];
    sb.push_back('{0, 8'h55, 1'b0});
    send_frame(0, 8'h55, -1, 1, 0);
    e = e_last;
    wait_rdy(0, 50);
    chk("t1_rise_count", rise_cnt[0] - rc, 1);
    chk("t1_rise_cycle", rise_cyc[0], e + 99);
    pop_check(0);
    chk("t1_overrun", ovr_o[0], 1'b0);
    ack_pulse(0);
    chk("t1_ack_clears_ready", rdy_o[0], 1'b0);

    // False start: 3 cycles low
    rc = rise_cnt[0];
    fc = ferr_cnt[0];
    rx_i[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rx_i[0] = 1'b1;
    chk("t2_start_entered", u_n1.r_state, S_START);
    repeat (6) @(posedge clk);
    #1;
    chk("t2_idle_by_t0p6", u_n1.r_state, S_IDLE);
    repeat (120) @(posedge clk);
    #1;
    chk("t2_no_ready", rise_cnt[0] - rc, 0);
    chk("t2_no_ferr", ferr_cnt[0] - fc, 0);

    // Framing error, then a valid word after the line recovers
    rc = rise_cnt[0];
    fc = ferr_cnt[0];
    send_frame(0, 8'hA3, -1, 1, 40);
    e = e_last;
    repeat (2 * BT) @(posedge clk);
    #1;
    chk("t3_ferr_once", ferr_cnt[0] - fc, 1);
    chk("t3_ferr_cycle", ferr_cyc[0], e + 99);
    chk("t3_no_ready", rise_cnt[0] - rc, 0);
    chk("t3_ready_low", rdy_o[0], 1'b0);
    sb.push_back('{0, 8'h3C, 1'b0});
    send_frame(0, 8'h3C, -1, 1, 0);
    e = e_last;
    wait_rdy(0, 50);
    chk("t3_next_rise_cycle", rise_cyc[0], e + 99);
    pop_check(0);
    ack_pulse(0);

    // Even parity: wrong parity bit, then correct parity bit
    sb.push_back('{1, 8'hA5, 1'b1});
    send_frame(1, 8'hA5, 1, 1, 0);
    e = e_last;
    wait_rdy(1, 50);
    chk("t4_bad_rise_cycle", rise_cyc[1], e + 109);
    pop_check(1);
    ack_pulse(1);
    chk("t4_ack_clears_ready", rdy_o[1], 1'b0);
    sb.push_back('{1, 8'hA5, 1'b0});
    send_frame(1, 8'hA5, 0, 1, 0);
    e = e_last;
    wait_rdy(1, 50);
    chk("t4_good_rise_cycle", rise_cyc[1], e + 109);
    pop_check(1);
    ack_pulse(1);

    // Overrun on back-to-back words, then acknowledge on the accept edge
    rc = rise_cnt[0];
    sb.push_back('{0, 8'h11, 1'b0});
    send_frame(0, 8'h11, -1, 1, 0);
    send_frame(0, 8'h22, -1, 1, 0);
    wait_rdy(0, 50);
    chk("t5_single_rise", rise_cnt[0] - rc, 1);
    pop_check(0);
    chk("t5_overrun_set", ovr_o[0], 1'b1);
    ack_pulse(0);
    chk("t5_ack_clears_ready", rdy_o[0], 1'b0);
    chk("t5_ack_clears_ovr", ovr_o[0], 1'b0);
    sb.push_back('{0, 8'h44, 1'b0});
    send_frame(0, 8'h44, -1, 1, 0);
    wait_rdy(0, 50);
    pop_check(0);
    sb.push_back('{0, 8'h33, 1'b0});
    fork
      send_frame(0, 8'h33, -1, 1, 0);
      begin
        repeat (98) @(posedge clk);
        #1;
        ack_i[0] = 1'b1;
        @(posedge clk);
        #1;
        ack_i[0] = 1'b0;
      end
    join
    wait_rdy(0, 50);
    pop_check(0);
    chk("t5_sim_ack_no_ovr", ovr_o[0], 1'b0);

    // Reset mid-frame, then 8N2 reception
    rx_i[2] = 1'b0;
    repeat (43) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("t6_rst_ready", rdy_o[k], 1'b0);
      chk("t6_rst_data", data_o[k], 8'h00);
      chk("t6_rst_perr", perr_o[k], 1'b0);
      chk("t6_rst_ferr", ferr_o[k], 1'b0);
      chk("t6_rst_ovr", ovr_o[k], 1'b0);
    end
    chk("t6_rst_state", u_n2.r_state, S_IDLE);
    chk("t6_rst_cnt", u_n2.r_cnt, 0);
    rx_i[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2 * BT) @(posedge clk);
    #1;
    rc = rise_cnt[2];
    sb.push_back('{2, 8'h7E, 1'b0});
    send_frame(2, 8'h7E, -1, 2, 0);
    e = e_last;
    wait_rdy(2, 50);
    chk("t6_rise_count", rise_cnt[2] - rc, 1);
    chk("t6_rise_cycle", rise_cyc[2], e + 109);
    pop_check(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
